// File: rtl/biu_master_seq_if.sv
// Client request, slave status and BIU command signals of the SDRAM bus master.
// The master modport is the sequencer's view; the slave modport is the client/BIU side.
interface biu_master_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [29:0] req_addr;
    logic [3:0]  req_burst;
    logic [1:0]  req_size;
    logic        stop_req;
    logic        stall;
    logic [2:0]  StateCountIn;
    logic [7:0]  TimerCountIn;
    logic [8:0]  Control;
    logic [31:0] AddrOut;
    logic        En;
    logic        done;
    logic        err;

    modport master (
        input  req_valid, req_op, req_addr, req_burst, req_size,
        input  stop_req, stall, StateCountIn, TimerCountIn,
        output req_ready, Control, AddrOut, En, done, err
    );

    modport slave (
        output req_valid, req_op, req_addr, req_burst, req_size,
        output stop_req, stall, StateCountIn, TimerCountIn,
        input  req_ready, Control, AddrOut, En, done, err
    );
endinterface

// File: rtl/biu_master_seq.sv
// Sequences single client requests into timed Control/AddrOut/En commands for the SDRAM BIU.
// Latency: all outputs registered, first bus cycle appears one clock after the request is accepted.
// Backpressure: req_ready only in IDLE with the slave idle; stall raises the busy state field.
module biu_master_seq #(
    parameter int PROG_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_BITS       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    biu_master_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_XFER, S_STOP, S_SPECIAL, S_DONE
    } state_t;

    localparam logic [CNT_BITS-1:0] TMO_LAST  = CNT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] PROG_LAST = CNT_BITS'(PROG_CYCLES - 1);

    state_t              state, next_state;
    logic [1:0]          op_q;
    logic [29:0]         addr_q;
    logic [3:0]          burst_q;
    logic [1:0]          size_q;
    logic [CNT_BITS-1:0] cnt;
    logic                tmo_q;

    logic                accept, illegal, tmo_hit;
    logic [1:0]          op_n;
    logic [29:0]         addr_n;
    logic [3:0]          burst_n;
    logic [1:0]          size_n;

    logic [8:0]          control_d;
    logic [31:0]         addr_d;
    logic                en_d, ready_d, done_d, err_d;

    assign accept  = (state == S_IDLE) && bus.req_valid && bus.req_ready;
    assign illegal = !bus.req_op[1] && (bus.req_addr >= 30'h3FFF_FFF0);
    assign tmo_hit = ((state == S_ISSUE) || (state == S_XFER)) && (cnt == TMO_LAST);

    // Output decode looks at the request being accepted this edge, not the stale latch.
    assign op_n    = accept ? bus.req_op    : op_q;
    assign addr_n  = accept ? bus.req_addr  : addr_q;
    assign burst_n = accept ? bus.req_burst : burst_q;
    assign size_n  = accept ? bus.req_size  : size_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            size_q  <= '0;
            cnt     <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                burst_q <= bus.req_burst;
                size_q  <= bus.req_size;
                cnt     <= '0;
            end else if ((state == S_ISSUE) || (state == S_XFER) || (state == S_SPECIAL)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state == S_DONE)
                tmo_q <= 1'b0;
            else if (tmo_hit)
                tmo_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)           next_state = S_DONE;
                    else if (bus.req_op[1]) next_state = S_SPECIAL;
                    else                   next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tmo_hit)                         next_state = S_STOP;
                else if (bus.StateCountIn != 3'b000) next_state = S_XFER;
            end
            S_XFER: begin
                if (bus.stop_req || tmo_hit)         next_state = S_STOP;
                else if (bus.StateCountIn == 3'b000) next_state = S_DONE;
            end
            S_STOP:  next_state = S_DONE;
            // Program runs a fixed count; self-refresh stays until the client releases it.
            S_SPECIAL: begin
                if (op_q == 2'b10) begin
                    if (cnt == PROG_LAST) next_state = S_DONE;
                end else if (bus.stop_req) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        control_d = {2'b10, 7'b0};
        addr_d    = '0;
        en_d      = 1'b0;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (next_state)
            S_IDLE: begin
                ready_d = (bus.StateCountIn == 3'b000) && (bus.TimerCountIn <= 8'd1);
            end
            S_ISSUE: begin
                control_d = {2'b01, burst_n, size_n, op_n[0]};
                addr_d    = {2'b00, addr_n};
                en_d      = 1'b1;
            end
            S_XFER: begin
                control_d = {2'b01, burst_n, size_n, op_n[0]};
                if ((op_n == 2'b01) && bus.stall && (bus.StateCountIn == 3'b100))
                    control_d[8:7] = 2'b11;
                addr_d = {2'b00, addr_n};
                en_d   = 1'b1;
            end
            S_STOP: begin
                control_d = {2'b01, burst_n, size_n, op_n[0]};
                addr_d    = 32'h3FFF_FFF1;
                en_d      = 1'b1;
            end
            S_SPECIAL: begin
                addr_d = (op_n == 2'b10) ? 32'h3FFF_FFFF : 32'h3FFF_FFF0;
                en_d   = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                // Entering DONE straight from IDLE only happens for a rejected address.
                err_d  = (state == S_IDLE) || tmo_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bus.Control   <= {2'b10, 7'b0};
            bus.AddrOut   <= '0;
            bus.En        <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.Control   <= control_d;
            bus.AddrOut   <= addr_d;
            bus.En        <= en_d;
            bus.req_ready <= ready_d;
            bus.done      <= done_d;
            bus.err       <= err_d;
        end
    end
endmodule
